decode_wb: RTL and testbench
============================

DECODE_WB -- requirements
Module: decode_wb

Interface
REQ-001 SHALL have parameter RSP_INIT, default 64'h200, the reset value of register 4 (%rsp).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports icode, ifun, rA, rB, input, 4 each, the decoded fields from fetch.
REQ-005 SHALL have ports valC, valP, input, 64 each, the constant and next-PC values from fetch.
REQ-006 SHALL have ports instr_val, imem_er, halt, input, 1 each, the fetch status flags.
REQ-007 SHALL have ports w_dstE, w_dstM, input, 4 each, the write-back register IDs (4'hF = none).
REQ-008 SHALL have ports w_valE, w_valM, input, 64 each, the write-back data.
REQ-009 SHALL have ports e_stall, e_bubble, input, 1 each, the pipeline-register control inputs.
REQ-010 SHALL have ports e_icode, e_ifun, e_dstE, e_dstM, e_srcA, e_srcB, output, 4 each, registered.
REQ-011 SHALL have ports e_valC, e_valA, e_valB, output, 64 each, registered.
REQ-012 SHALL have port e_stat, output, 3, registered status: BUB=0, AOK=1, HLT=2, ADR=3, INS=4.

Function
REQ-013 SHALL hold 15 x 64-bit registers, IDs 0-14; ID 15 (RNONE) SHALL never be written, and a read of it SHALL return 0.
REQ-014 SHALL select srcA: rA for icode 2, 4, 6 and A; 4 for icode 9 and B; otherwise F.
REQ-015 SHALL select srcB: rB for icode 4, 5 and 6; 4 for icode 8, 9, A and B; otherwise F.
REQ-016 SHALL select dstE: rB for icode 2, 3 and 6; 4 for icode 8, 9, A and B; otherwise F. Cmov suppression is left to the execute stage.
REQ-017 SHALL select dstM: rA for icode 5 and B; otherwise F.
REQ-018 SHALL make valA equal to valP for icode 7 and 8; otherwise it is the bypassed read of srcA.
REQ-019 SHALL make valB the bypassed read of srcB.
REQ-020 SHALL bypass reads: if src equals w_dstM, return w_valM; else if src equals w_dstE, return w_valE; else return the register contents. This holds only when src is not F.
REQ-021 SHALL write w_valE to w_dstE and w_valM to w_dstM on the rising edge when the ID is not F.
REQ-022 SHALL write only w_valM when w_dstE equals w_dstM (not F).
REQ-023 SHALL set stat with this priority: imem_er gives ADR; else !instr_val gives INS; else icode==0 or halt gives HLT; else AOK.
REQ-024 SHALL, on each edge, apply pipeline-register control with this priority: e_bubble loads the bubble; else e_stall holds all e_* outputs; else it loads the decoded values.
REQ-025 SHALL define the bubble as: icode=1, ifun=0, all IDs=F, valA=valB=valC=0, stat=BUB.
REQ-026 SHALL perform register-file writes regardless of e_stall and e_bubble.
REQ-027 SHALL have a decode-to-e_* latency of exactly one clock. Register reads SHALL be combinational.

Reset
REQ-028 SHALL, while rst=1, force all e_* outputs to the bubble values of REQ-025 immediately, with no clock needed.
REQ-029 SHALL, on reset, clear registers 0-3 and 5-14 to 0 and set register 4 to RSP_INIT.
REQ-030 SHALL abort any in-flight write on a reset asserted mid-operation; the first write after release SHALL occur on the first rising edge with rst=0.

Structure
REQ-031 SHALL place the icode constants (HALT..POPQ), RNONE=4'hF, RSP=4'h4 and the stat codes in a shared package y86_pkg, which fetch also uses.
REQ-032 SHALL implement the register file as one sub-module, regfile (2 read ports, 2 write ports, async reset), with bypass logic kept in decode_wb.

Verification
REQ-033 SHALL verify reset: assert rst with no clock, then read all registers after release. Required: e_stat=0, e_icode=1, register 4 = 64'h200, and all others 0.
REQ-034 SHALL verify irmovq then read: write w_dstE=2, w_valE=64'h10, then present OPq icode=6, rA=2, rB=3. Required: e_valA=64'h10 one cycle later.
REQ-035 SHALL verify same-cycle bypass: present w_dstM=5, w_valM=64'hAB and w_dstE=5, w_valE=64'hCD while decoding rA=5 for icode=6. Required: e_valA=64'hAB, and register 5 holds 64'hAB afterwards.
REQ-036 SHALL verify popq: present icode=B, rA=1. Required: e_srcA=4, e_srcB=4, e_dstE=4, e_dstM=1, e_valA=e_valB=64'h200.
REQ-037 SHALL verify stall/bubble: hold e_stall=1 for 2 cycles, then assert e_stall=1 and e_bubble=1 together. Required: outputs are held for 2 cycles, then the bubble is loaded (e_stat=0).
REQ-038 SHALL verify status priority: present imem_er=1, instr_val=0, icode=0. Required: e_stat=ADR. Then present call icode=8, valP=64'h29. Required: e_valA=64'h29 and e_dstE=4.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by fetch and decode: instruction codes,
// register IDs, status codes and the decode-to-execute register bundle.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RSP    = 4'h4;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [63:0] val_c;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [2:0]  stat;
    } e_reg_t;

    // A bubble behaves as a nop that carries no register traffic.
    function automatic e_reg_t bubble_e();
        e_reg_t b;
        b       = '0;
        b.icode = NOP;
        b.dst_e = RNONE;
        b.dst_m = RNONE;
        b.src_a = RNONE;
        b.src_b = RNONE;
        b.stat  = STAT_BUB;
        return b;
    endfunction

endpackage

// File: rtl/regfile.sv
// Y86-64 register file: 15 x 64-bit registers, two combinational read ports,
// two write ports (M wins over E on a shared ID), async active-high reset.
module regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_src_a,
    input  logic [3:0]  i_src_b,
    output logic [63:0] o_rd_a,
    output logic [63:0] o_rd_b,
    input  logic [3:0]  i_dst_e,
    input  logic [63:0] i_val_e,
    input  logic [3:0]  i_dst_m,
    input  logic [63:0] i_val_m
);

    logic [63:0] r_regs [0:14];
    logic        w_we_e;
    logic        w_we_m;

    assign w_we_m = (i_dst_m != RNONE);
    assign w_we_e = (i_dst_e != RNONE) && (i_dst_e != i_dst_m);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= (4'(i) == RSP) ? RSP_INIT : '0;
            end
        end else begin
            if (w_we_e) r_regs[i_dst_e] <= i_val_e;
            if (w_we_m) r_regs[i_dst_m] <= i_val_m;
        end
    end

    assign o_rd_a = (i_src_a == RNONE) ? '0 : r_regs[i_src_a];
    assign o_rd_b = (i_src_b == RNONE) ? '0 : r_regs[i_src_b];

endmodule

// File: rtl/decode_wb.sv
// Y86-64 decode / write-back stage: register-ID selection, forwarding from
// write-back, status generation and the E pipeline register.
module decode_wb
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_val,
    input  logic        imem_er,
    input  logic        halt,
    input  logic [3:0]  w_dstE,
    input  logic [3:0]  w_dstM,
    input  logic [63:0] w_valE,
    input  logic [63:0] w_valM,
    input  logic        e_stall,
    input  logic        e_bubble,
    output logic [3:0]  e_icode,
    output logic [3:0]  e_ifun,
    output logic [3:0]  e_dstE,
    output logic [3:0]  e_dstM,
    output logic [3:0]  e_srcA,
    output logic [3:0]  e_srcB,
    output logic [63:0] e_valC,
    output logic [63:0] e_valA,
    output logic [63:0] e_valB,
    output logic [2:0]  e_stat
);

    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic [63:0] w_rd_a;
    logic [63:0] w_rd_b;
    logic [63:0] w_fwd_a;
    logic [63:0] w_fwd_b;
    logic [2:0]  w_stat;
    e_reg_t      w_dec;
    e_reg_t      r_e;

    regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_src_a (w_src_a),
        .i_src_b (w_src_b),
        .o_rd_a  (w_rd_a),
        .o_rd_b  (w_rd_b),
        .i_dst_e (w_dstE),
        .i_val_e (w_valE),
        .i_dst_m (w_dstM),
        .i_val_m (w_valM)
    );

    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (icode)
            RRMOVQ: begin w_src_a = rA;  w_dst_e = rB; end
            IRMOVQ: begin w_dst_e = rB; end
            RMMOVQ: begin w_src_a = rA;  w_src_b = rB; end
            MRMOVQ: begin w_src_b = rB;  w_dst_m = rA; end
            OPQ:    begin w_src_a = rA;  w_src_b = rB;  w_dst_e = rB; end
            CALL:   begin w_src_b = RSP; w_dst_e = RSP; end
            RET:    begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; end
            PUSHQ:  begin w_src_a = rA;  w_src_b = RSP; w_dst_e = RSP; end
            POPQ:   begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; w_dst_m = rA; end
            default: ;
        endcase
    end

    // M is checked before E so the read matches what the register will hold.
    assign w_fwd_a = (w_src_a == RNONE)  ? '0     :
                     (w_src_a == w_dstM) ? w_valM :
                     (w_src_a == w_dstE) ? w_valE : w_rd_a;
    assign w_fwd_b = (w_src_b == RNONE)  ? '0     :
                     (w_src_b == w_dstM) ? w_valM :
                     (w_src_b == w_dstE) ? w_valE : w_rd_b;

    always_comb begin
        w_stat = STAT_AOK;
        if (imem_er)                        w_stat = STAT_ADR;
        else if (!instr_val)                w_stat = STAT_INS;
        else if ((icode == HALT) || halt)   w_stat = STAT_HLT;
    end

    always_comb begin
        w_dec       = '0;
        w_dec.icode = icode;
        w_dec.ifun  = ifun;
        w_dec.dst_e = w_dst_e;
        w_dec.dst_m = w_dst_m;
        w_dec.src_a = w_src_a;
        w_dec.src_b = w_src_b;
        w_dec.val_c = valC;
        w_dec.val_a = ((icode == JXX) || (icode == CALL)) ? valP : w_fwd_a;
        w_dec.val_b = w_fwd_b;
        w_dec.stat  = w_stat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_e <= bubble_e();
        else if (e_bubble)  r_e <= bubble_e();
        else if (!e_stall)  r_e <= w_dec;
    end

    assign e_icode = r_e.icode;
    assign e_ifun  = r_e.ifun;
    assign e_dstE  = r_e.dst_e;
    assign e_dstM  = r_e.dst_m;
    assign e_srcA  = r_e.src_a;
    assign e_srcB  = r_e.src_b;
    assign e_valC  = r_e.val_c;
    assign e_valA  = r_e.val_a;
    assign e_valB  = r_e.val_b;
    assign e_stat  = r_e.stat;

endmodule

// File: tb/tb_decode_wb.sv
// Self-checking bench for decode_wb: directed vector table, hand-written
// stall/bubble/reset sequences and randomized traffic against a register-array model.
module tb_decode_wb;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode, ifun, rA, rB, w_dstE, w_dstM;
    logic [63:0] valC, valP, w_valE, w_valM;
    logic        instr_val, imem_er, halt, e_stall, e_bubble;
    logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM, e_srcA, e_srcB;
    logic [63:0] e_valC, e_valA, e_valB;
    logic [2:0]  e_stat;

    decode_wb #(.RSP_INIT(64'h200)) dut (
        .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_val(instr_val), .imem_er(imem_er),
        .halt(halt), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE),
        .w_valM(w_valM), .e_stall(e_stall), .e_bubble(e_bubble),
        .e_icode(e_icode), .e_ifun(e_ifun), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .e_srcA(e_srcA), .e_srcB(e_srcB), .e_valC(e_valC), .e_valA(e_valA),
        .e_valB(e_valB), .e_stat(e_stat)
    );

    always #5 if (clk_en) clk = ~clk;

    localparam logic [3:0] F = 4'hF;

    typedef struct packed {
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic        instr_val, imem_er, halt;
        logic [3:0]  w_dstE, w_dstM;
        logic [63:0] w_valE, w_valM;
        logic        stall, bubble;
    } vec_in_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, srcA, srcB, dstE, dstM;
        logic [63:0] valC, valA, valB;
    } exp_t;

    typedef struct {
        vec_in_t     vi;
        logic [2:0]  stat;
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA, valB;
    } vec_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] m_regs [16];
    exp_t        m_exp;

    function automatic vec_in_t op(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb, logic [63:0] vp);
        vec_in_t v;
        v = '0;
        v.icode = ic; v.rA = ra; v.rB = rb; v.valP = vp;
        v.instr_val = 1'b1;
        v.w_dstE = F; v.w_dstM = F;
        return v;
    endfunction

    function automatic vec_in_t wr(vec_in_t v0, logic [3:0] de, logic [63:0] ve, logic [3:0] dm, logic [63:0] vm);
        vec_in_t v;
        v = v0;
        v.w_dstE = de; v.w_valE = ve; v.w_dstM = dm; v.w_valM = vm;
        return v;
    endfunction

    function automatic vec_in_t flags(vec_in_t v0, logic iv, logic ie, logic h);
        vec_in_t v;
        v = v0;
        v.instr_val = iv; v.imem_er = ie; v.halt = h;
        return v;
    endfunction

    function automatic exp_t bubble_exp();
        exp_t b;
        b = '0;
        b.icode = 4'h1;
        b.srcA = F; b.srcB = F; b.dstE = F; b.dstM = F;
        return b;
    endfunction

    function automatic exp_t act_now();
        return {e_stat, e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM, e_valC, e_valA, e_valB};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_regs[4] = 64'h200;
        m_exp = bubble_exp();
    endtask

    task automatic chk(string name, logic [255:0] act, logic [255:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Reference: a read sees the register file as it stands after this
    // cycle's write-back (M overriding E), and slot 15 always reads zero.
    task automatic model_step(vec_in_t v);
        exp_t d;
        if (v.w_dstE != F) m_regs[v.w_dstE] = v.w_valE;
        if (v.w_dstM != F) m_regs[v.w_dstM] = v.w_valM;
        d.icode = v.icode;
        d.ifun  = v.ifun;
        d.valC  = v.valC;
        d.srcA  = (v.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? v.rA :
                  (v.icode inside {4'h9, 4'hB}) ? 4'h4 : F;
        d.srcB  = (v.icode inside {4'h4, 4'h5, 4'h6}) ? v.rB :
                  (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : F;
        d.dstE  = (v.icode inside {4'h2, 4'h3, 4'h6}) ? v.rB :
                  (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : F;
        d.dstM  = (v.icode inside {4'h5, 4'hB}) ? v.rA : F;
        d.valA  = (v.icode inside {4'h7, 4'h8}) ? v.valP : m_regs[d.srcA];
        d.valB  = m_regs[d.srcB];
        d.stat  = v.imem_er ? 3'd3 : !v.instr_val ? 3'd4 :
                  (v.icode == 4'h0 || v.halt) ? 3'd2 : 3'd1;
        if (v.bubble)      m_exp = bubble_exp();
        else if (!v.stall) m_exp = d;
    endtask

    task automatic drive(vec_in_t v);
        icode = v.icode; ifun = v.ifun; rA = v.rA; rB = v.rB;
        valC = v.valC; valP = v.valP;
        instr_val = v.instr_val; imem_er = v.imem_er; halt = v.halt;
        w_dstE = v.w_dstE; w_dstM = v.w_dstM; w_valE = v.w_valE; w_valM = v.w_valM;
        e_stall = v.stall; e_bubble = v.bubble;
    endtask

    task automatic step(vec_in_t v);
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
        chk("model", 256'(act_now()), 256'(m_exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    vec_t    tbl [14];
    vec_in_t v;

    initial begin
        tbl[0]  = '{vi: wr(op(4'h1, F, F, 0), 4'h2, 64'h10, F, 0),           stat: 3'd1, srcA: F,    srcB: F,    dstE: F,    dstM: F,    valA: 64'h0,   valB: 64'h0};
        tbl[1]  = '{vi: op(4'h6, 4'h2, 4'h3, 0),                             stat: 3'd1, srcA: 4'h2, srcB: 4'h3, dstE: 4'h3, dstM: F,    valA: 64'h10,  valB: 64'h0};
        tbl[2]  = '{vi: wr(op(4'h6, 4'h5, 4'h2, 0), 4'h5, 64'hCD, 4'h5, 64'hAB), stat: 3'd1, srcA: 4'h5, srcB: 4'h2, dstE: 4'h2, dstM: F, valA: 64'hAB,  valB: 64'h10};
        tbl[3]  = '{vi: op(4'h2, 4'h5, 4'h6, 0),                             stat: 3'd1, srcA: 4'h5, srcB: F,    dstE: 4'h6, dstM: F,    valA: 64'hAB,  valB: 64'h0};
        tbl[4]  = '{vi: op(4'hB, 4'h1, F, 0),                                stat: 3'd1, srcA: 4'h4, srcB: 4'h4, dstE: 4'h4, dstM: 4'h1, valA: 64'h200, valB: 64'h200};
        tbl[5]  = '{vi: flags(op(4'h0, F, F, 0), 1'b0, 1'b1, 1'b0),          stat: 3'd3, srcA: F,    srcB: F,    dstE: F,    dstM: F,    valA: 64'h0,   valB: 64'h0};
        tbl[6]  = '{vi: flags(op(4'h6, 4'h2, 4'h5, 0), 1'b0, 1'b0, 1'b0),    stat: 3'd4, srcA: 4'h2, srcB: 4'h5, dstE: 4'h5, dstM: F,    valA: 64'h10,  valB: 64'hAB};
        tbl[7]  = '{vi: flags(op(4'h1, F, F, 0), 1'b1, 1'b0, 1'b1),          stat: 3'd2, srcA: F,    srcB: F,    dstE: F,    dstM: F,    valA: 64'h0,   valB: 64'h0};
        tbl[8]  = '{vi: op(4'h8, F, F, 64'h29),                              stat: 3'd1, srcA: F,    srcB: 4'h4, dstE: 4'h4, dstM: F,    valA: 64'h29,  valB: 64'h200};
        tbl[9]  = '{vi: wr(op(4'h5, 4'h7, 4'h4, 0), 4'h4, 64'h300, F, 0),    stat: 3'd1, srcA: F,    srcB: 4'h4, dstE: F,    dstM: 4'h7, valA: 64'h0,   valB: 64'h300};
        tbl[10] = '{vi: op(4'h7, F, F, 64'h55),                              stat: 3'd1, srcA: F,    srcB: F,    dstE: F,    dstM: F,    valA: 64'h55,  valB: 64'h0};
        tbl[11] = '{vi: op(4'h4, 4'h4, 4'h5, 0),                             stat: 3'd1, srcA: 4'h4, srcB: 4'h5, dstE: F,    dstM: F,    valA: 64'h300, valB: 64'hAB};
        tbl[12] = '{vi: wr(op(4'h2, F, F, 0), F, 64'hDEAD, F, 64'hBEEF),     stat: 3'd1, srcA: F,    srcB: F,    dstE: F,    dstM: F,    valA: 64'h0,   valB: 64'h0};
        tbl[13] = '{vi: op(4'hA, 4'h3, F, 0),                                stat: 3'd1, srcA: 4'h3, srcB: 4'h4, dstE: 4'h4, dstM: F,    valA: 64'h0,   valB: 64'h300};

        drive(op(4'h1, F, F, 0));
        model_reset();

        // Reset with the clock stopped: outputs must go to the bubble at once.
        #1 rst = 1'b1;
        #2;
        chk("rst_stat",  256'(e_stat),  256'(3'd0));
        chk("rst_icode", 256'(e_icode), 256'(4'h1));
        chk("rst_srcA",  256'(e_srcA),  256'(F));
        chk("rst_valA",  256'(e_valA),  256'(64'h0));
        #2 rst = 1'b0;
        #1 clk_en = 1'b1;

        for (int r = 0; r < 15; r++) begin
            step(op(4'h2, 4'(r), F, 0));
            chk($sformatf("rst_reg%0d", r), 256'(e_valA), (r == 4) ? 256'(64'h200) : 256'(0));
        end

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].vi);
            chk($sformatf("tbl%0d.stat", i), 256'(e_stat), 256'(tbl[i].stat));
            chk($sformatf("tbl%0d.srcA", i), 256'(e_srcA), 256'(tbl[i].srcA));
            chk($sformatf("tbl%0d.srcB", i), 256'(e_srcB), 256'(tbl[i].srcB));
            chk($sformatf("tbl%0d.dstE", i), 256'(e_dstE), 256'(tbl[i].dstE));
            chk($sformatf("tbl%0d.dstM", i), 256'(e_dstM), 256'(tbl[i].dstM));
            chk($sformatf("tbl%0d.valA", i), 256'(e_valA), 256'(tbl[i].valA));
            chk($sformatf("tbl%0d.valB", i), 256'(e_valB), 256'(tbl[i].valB));
        end
        step(op(4'h2, 4'h5, F, 0));
        chk("bypass_reg5", 256'(e_valA), 256'(64'hAB));

        // Two stall cycles hold the E register while register writes still land.
        step(op(4'h6, 4'h2, 4'h5, 0));
        for (int k = 0; k < 2; k++) begin
            v = wr(op(4'hB, 4'h1, F, 0), 4'h9, 64'h99, F, 0);
            v.stall = 1'b1;
            step(v);
            chk($sformatf("stall%0d.icode", k), 256'(e_icode), 256'(4'h6));
            chk($sformatf("stall%0d.valA", k),  256'(e_valA),  256'(64'h10));
            chk($sformatf("stall%0d.valB", k),  256'(e_valB),  256'(64'hAB));
            chk($sformatf("stall%0d.dstE", k),  256'(e_dstE),  256'(4'h5));
        end
        v = op(4'h8, F, F, 64'h77);
        v.stall = 1'b1; v.bubble = 1'b1;
        step(v);
        chk("bubble.stat",  256'(e_stat),  256'(3'd0));
        chk("bubble.icode", 256'(e_icode), 256'(4'h1));
        chk("bubble.dstE",  256'(e_dstE),  256'(F));
        chk("bubble.valA",  256'(e_valA),  256'(64'h0));
        step(op(4'h2, 4'h9, F, 0));
        chk("stall_write", 256'(e_valA), 256'(64'h99));

        for (int n = 0; n < 400; n++) begin
            v = '0;
            v.icode = 4'($urandom_range(0, 15));
            v.ifun  = 4'($urandom_range(0, 15));
            v.rA    = 4'($urandom_range(0, 15));
            v.rB    = 4'($urandom_range(0, 15));
            v.valC  = {$urandom, $urandom};
            v.valP  = {$urandom, $urandom};
            v.instr_val = ($urandom_range(0, 9) != 0);
            v.imem_er   = ($urandom_range(0, 11) == 0);
            v.halt      = ($urandom_range(0, 9) == 0);
            v.w_dstE = ($urandom_range(0, 1) == 0) ? F : 4'($urandom_range(0, 14));
            v.w_dstM = ($urandom_range(0, 2) == 0) ? v.w_dstE :
                       ($urandom_range(0, 1) == 0) ? F : 4'($urandom_range(0, 14));
            v.w_valE = {$urandom, $urandom};
            v.w_valM = {$urandom, $urandom};
            v.stall  = ($urandom_range(0, 4) == 0);
            v.bubble = ($urandom_range(0, 7) == 0);
            step(v);
        end

        // Reset mid-run with a write pending; it must be dropped.
        drive(wr(op(4'h6, 4'h3, 4'h5, 0), 4'h3, 64'h1234, 4'h5, 64'h5678));
        #2 rst = 1'b1;
        #1;
        chk("midrst_stat",  256'(e_stat),  256'(3'd0));
        chk("midrst_icode", 256'(e_icode), 256'(4'h1));
        chk("midrst_srcB",  256'(e_srcB),  256'(F));
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        step(wr(op(4'h2, 4'h5, F, 0), 4'h3, 64'h77, F, 0));
        chk("midrst_reg5", 256'(e_valA), 256'(64'h0));
        step(op(4'h2, 4'h3, F, 0));
        chk("post_rst_write", 256'(e_valA), 256'(64'h77));
        step(op(4'h2, 4'h4, F, 0));
        chk("post_rst_rsp", 256'(e_valA), 256'(64'h200));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
